avg_decimator: RTL and testbench
================================

AVG_DECIMATOR -- requirements
Module: avg_decimator

Interface
REQ-001 SHALL have parameter WIDTH, default 32: sample width, two's complement.
REQ-002 SHALL have parameter DECIM, default 4: keep-one-in-DECIM ratio, legal range 1..256.
REQ-003 SHALL have parameter DEPTH, default 4: output FIFO entries, a power of 2, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_avg valid this cycle; no backpressure upstream.
REQ-007 SHALL have port in_avg, input, signed [WIDTH-1:0]: moving-average sample from the averaging stage.
REQ-008 SHALL have port out_valid, output, 1 bit: FIFO head valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the head.
REQ-010 SHALL have port out_data, output, signed [WIDTH-1:0]: FIFO head sample.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag for a dropped decimated sample.
REQ-012 SHALL have port level, output, [clog2(DEPTH):0]: current FIFO occupancy.

Function
REQ-013 SHALL keep a phase counter over 0..DECIM-1, incremented on each cycle with in_valid=1 and wrapping from DECIM-1 to 0.
REQ-014 SHALL generate a push only when in_valid=1 and phase==0, so the 1st, (DECIM+1)th, ... valid samples are kept; with DECIM=1 every valid sample is kept.
REQ-015 SHALL hold phase and FIFO state in any cycle with in_valid=0.
REQ-016 SHALL complete a pop when out_valid=1 and out_ready=1 in the same cycle.
REQ-017 SHALL assert out_valid exactly when level is nonzero; no combinational path from in_valid to out_valid.
REQ-018 SHALL show a pushed sample at out_data with out_valid=1 on the cycle after the push edge when the FIFO was empty; no bypass.
REQ-019 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL deliver samples in push order, bit-exact, with no arithmetic applied.
REQ-021 SHALL, on push with level==DEPTH and a pop in the same cycle, accept the push and leave level unchanged.
REQ-022 SHALL, on push with level==DEPTH and no pop, drop the sample, set overflow, and leave FIFO contents and pointers unchanged.
REQ-023 SHALL, on simultaneous push and pop with 0<level<DEPTH, keep level unchanged and advance both pointers.
REQ-024 SHALL ignore a pop request when the FIFO is empty (out_valid=0).
REQ-025 SHALL wrap read and write pointers modulo DEPTH; level SHALL be an explicit count, not a pointer difference.
REQ-026 SHALL keep overflow at 1 once set, until reset.

Reset
REQ-027 SHALL, on assertion of rst (low), asynchronously clear phase, pointers, level, and overflow, and drive out_valid=0 and out_data=0.
REQ-028 SHALL discard FIFO contents on reset mid-operation; no data from before reset SHALL appear afterwards.
REQ-029 SHALL honour the first push on the first rising clk edge after rst deasserts.

Structure
REQ-030 SHALL take the clog2 function and the default WIDTH constant from the shared package also used by the averaging stage.
REQ-031 SHALL implement the FIFO as one sub-module, avg_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level), with the decimation counter and overflow logic in avg_decimator.

Verification
REQ-032 SHALL cover: DECIM=4, in_valid=1 continuously with in_avg=1..12, out_ready=1 -> out_data sequence 1,5,9, each one cycle after its push.
REQ-033 SHALL cover: DECIM=1, DEPTH=4, out_ready=0, push 10,20,30,40,50 -> level=4, overflow=1; then out_ready=1 -> 10,20,30,40 only.
REQ-034 SHALL cover: DECIM=1, FIFO full, out_ready=1 and push of -7 in the same cycle -> overflow stays 0, level stays 4, -7 emerges last.
REQ-035 SHALL cover: in_valid toggling 1,0,1,0 with DECIM=2 and in_avg=3,x,4,x -> only 3 pushed; phase frozen on idle cycles.
REQ-036 SHALL cover: rst asserted with level=3 and overflow=1 -> same-cycle out_valid=0, level=0, overflow=0; after release, first push of 0x7FFFFFFF emerges unchanged.
REQ-037 SHALL cover: out_ready randomized 50% with DECIM=3 over 1000 samples -> output equals the scoreboard list of every 3rd sample, no overflow when the consumer averages at least 1/3 throughput.

Source files
------------

// File: rtl/avg_decimator_pkg.sv
// Constants and helpers shared by the averaging stage and the decimator.
package avg_decimator_pkg;

    localparam int AVG_WIDTH = 32;

    // Ceiling log2; bounded loop so it stays usable as a constant function.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/avg_fifo.sv
// Output FIFO for decimated samples: explicit occupancy count, wrapping pointers.
module avg_fifo
    import avg_decimator_pkg::*;
#(
    parameter int WIDTH = AVG_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                level <= level + (AW+1)'(1);
            else if (do_pop && !do_push)
                level <= level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Storage is not reset; gating on empty keeps stale entries invisible.
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/avg_decimator.sv
// Keeps one in DECIM valid moving-average samples and queues them for the consumer.
module avg_decimator
    import avg_decimator_pkg::*;
#(
    parameter int WIDTH = AVG_WIDTH,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [WIDTH-1:0]   in_avg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH-1:0]   out_data,
    output logic                      overflow,
    output logic [clog2(DEPTH):0]     level
);

    localparam int PW = (DECIM > 1) ? clog2(DECIM) : 1;

    logic [PW-1:0] phase;
    logic          push;
    logic          full;
    logic          empty;
    logic          drop;

    assign push = in_valid && (phase == '0);
    // When full the head is valid, so out_ready alone decides whether a slot frees up.
    assign drop = push && full && !out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase    <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_valid)
                phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
            if (drop)
                overflow <= 1'b1;
        end
    end

    avg_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_avg),
        .pop   (out_ready),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign out_valid = !empty;

endmodule

// File: tb/tb_avg_decimator.sv
// Scoreboard bench: four decimator instances (DECIM 4,1,2,3), one active per scenario.
module tb_avg_decimator;

    function automatic int dec_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            default: return 3;
        endcase
    endfunction

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              out_ready;
    logic signed [31:0] in_avg;
    int                cur;

    logic [3:0]        ov;
    logic [3:0][31:0]  od;
    logic [3:0]        ovf;
    logic [3:0][2:0]   lvl;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        avg_decimator #(
            .WIDTH (32),
            .DECIM (dec_of(g)),
            .DEPTH (4)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid && (cur == g)),
            .in_avg    (in_avg),
            .out_valid (ov[g]),
            .out_ready (out_ready && (cur == g)),
            .out_data  (od[g]),
            .overflow  (ovf[g]),
            .level     (lvl[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] q[$];
    int          cnt;
    bit          exp_ovf;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (dut %0d, t=%0t)", nm, act, exp, cur, $time);
        end
    endtask

    // Called at posedge+1: checks state left by the last edge, then drives one cycle.
    task automatic step(input logic v, input logic [31:0] d, input logic r);
        check("level", 32'(lvl[cur]), 32'(q.size()));
        check("out_valid", 32'(ov[cur]), 32'(q.size() != 0));
        check("overflow", 32'(ovf[cur]), 32'(exp_ovf));
        in_valid  = v;
        in_avg    = d;
        out_ready = r;
        if (v) begin
            if (cnt % dec_of(cur) == 0) begin
                if (q.size() == 4 && !r) exp_ovf = 1'b1;
                else q.push_back(d);
            end
            cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        #1;
        check("rst_out_valid", 32'(ov[cur]), 32'd0);
        check("rst_level", 32'(lvl[cur]), 32'd0);
        check("rst_overflow", 32'(ovf[cur]), 32'd0);
        check("rst_out_data", od[cur], 32'd0);
        q.delete();
        cnt     = 0;
        exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: a handshake seen at negedge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(ov[cur]), 32'd1);
                check("hold_data", od[cur], prev_data);
            end
            if (ov[cur] && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected none (dut %0d)", od[cur], cur);
                end else begin
                    check("out_data", od[cur], q[0]);
                    void'(q.pop_front());
                end
            end
            prev_stall <= ov[cur] && !out_ready;
            prev_data  <= od[cur];
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_avg = '0; cur = 0;
        cnt = 0; exp_ovf = 1'b0;
        @(posedge clk);
        #1;

        // DECIM=4, continuous input 1..12 -> 1,5,9
        cur = 0; do_reset();
        for (int k = 1; k <= 12; k++) step(1'b1, 32'(k), 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);
        check("s1_drained", 32'(q.size()), 32'd0);

        // DECIM=1, stalled consumer: fifth sample dropped, overflow set
        cur = 1; do_reset();
        for (int k = 1; k <= 5; k++) step(1'b1, 32'(10 * k), 1'b0);
        repeat (6) step(1'b0, '0, 1'b1);
        check("s2_drained", 32'(q.size()), 32'd0);

        // DECIM=1, full FIFO with push and pop together: -7 accepted, no overflow
        cur = 1; do_reset();
        for (int k = 1; k <= 4; k++) step(1'b1, 32'(k), 1'b0);
        step(1'b1, -32'sd7, 1'b1);
        repeat (6) step(1'b0, '0, 1'b1);
        check("s3_drained", 32'(q.size()), 32'd0);

        // DECIM=2, in_valid toggling: phase frozen on idle cycles
        cur = 2; do_reset();
        step(1'b1, 32'd3, 1'b1);
        step(1'b0, 32'd99, 1'b1);
        step(1'b1, 32'd4, 1'b1);
        step(1'b0, 32'd99, 1'b1);
        step(1'b1, 32'd5, 1'b1);
        repeat (3) step(1'b0, '0, 1'b1);
        check("s4_drained", 32'(q.size()), 32'd0);

        // Mid-operation reset with level=3 and overflow=1
        cur = 1; do_reset();
        for (int k = 1; k <= 4; k++) step(1'b1, 32'(k), 1'b0);
        step(1'b1, 32'd9, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("s5_pre_level", 32'(lvl[cur]), 32'd3);
        check("s5_pre_ovf", 32'(ovf[cur]), 32'd1);
        #2;
        do_reset();
        step(1'b1, 32'h7FFF_FFFF, 1'b1);
        repeat (3) step(1'b0, '0, 1'b1);
        check("s5_drained", 32'(q.size()), 32'd0);

        // DECIM=3, random data, consumer ready ~50%
        cur = 3; do_reset();
        for (int k = 0; k < 1000; k++) step(1'b1, $urandom, 1'($urandom_range(0, 1)));
        repeat (12) step(1'b0, '0, 1'b1);
        check("s6_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
